// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ----------------
// EX pipeline register of a 5-stage in-order pipeline, together with the
// operand forwarding network and the load-use hazard detector that sit
// around it.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   *_d                   decode-stage operands, register addresses, control
//   stall_e, flush_e      hold the EX register / load a bubble into it
//   aluout_m, writereg_m, regwrite_m
//                         MEM-stage result available for forwarding
//   result_w, writereg_w, regwrite_w
//                         WB-stage result available for forwarding
//   srca_e, srcb_e        forwarded ALU operands (B may be the immediate)
//   aluf_e                ALU function code
//   writedata_e           forwarded rt value for stores
//   writereg_e            destination register (rd or rt)
//   regwrite_e, memtoreg_e, memwrite_e, valid_e
//                         registered control bits
//   fwda_e, fwdb_e        forward selects (10 = MEM, 01 = WB, 00 = regfile)
//   lwstall               load-use stall request to the hazard unit
module ex_operand_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] signimm_d,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rd_d,
  input  logic [2:0]       alucontrol_d,
  input  logic             alusrc_d,
  input  logic             regdst_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic             valid_d,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [WIDTH-1:0] aluout_m,
  input  logic [4:0]       writereg_m,
  input  logic             regwrite_m,
  input  logic [WIDTH-1:0] result_w,
  input  logic [4:0]       writereg_w,
  input  logic             regwrite_w,
  output logic [WIDTH-1:0] srca_e,
  output logic [WIDTH-1:0] srcb_e,
  output logic [2:0]       aluf_e,
  output logic [WIDTH-1:0] writedata_e,
  output logic [4:0]       writereg_e,
  output logic             regwrite_e,
  output logic             memtoreg_e,
  output logic             memwrite_e,
  output logic             valid_e,
  output logic [1:0]       fwda_e,
  output logic [1:0]       fwdb_e,
  output logic             lwstall
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // EX pipeline register contents
  logic [WIDTH-1:0] rd1_p0;
  logic [WIDTH-1:0] rd2_p0;
  logic [WIDTH-1:0] imm_p0;
  logic [4:0]       rs_p0;
  logic [4:0]       rt_p0;
  logic [4:0]       rd_p0;
  logic [2:0]       aluctl_p0;
  logic             alusrc_p0;
  logic             regdst_p0;
  logic             regwrite_p0;
  logic             memtoreg_p0;
  logic             memwrite_p0;
  logic             vld_p0;

  // Forwarded operands
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;

  // Forward select for one source register. MEM is checked first so the
  // younger result wins when MEM and WB target the same register. Register
  // 0 is hard-wired to zero and is never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic       wr_m,
    input logic [4:0] dst_m,
    input logic       wr_w,
    input logic [4:0] dst_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (wr_m && (dst_m == src)) begin
        sel = FWD_MEM;
      end else if (wr_w && (dst_w == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  // Operand mux driven by a forward select; the unused code 11 falls back
  // to the register-file value so the output is never X.
  function automatic logic [WIDTH-1:0] fwd_mux(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] rf_val,
    input logic [WIDTH-1:0] m_val,
    input logic [WIDTH-1:0] w_val
  );
    logic [WIDTH-1:0] val;
    case (sel)
      FWD_MEM: val = m_val;
      FWD_WB:  val = w_val;
      default: val = rf_val;
    endcase
    return val;
  endfunction

  // ---- stage boundary: decode -> EX register ----
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      rd1_p0      <= '0;
      rd2_p0      <= '0;
      imm_p0      <= '0;
      rs_p0       <= '0;
      rt_p0       <= '0;
      rd_p0       <= '0;
      aluctl_p0   <= '0;
      alusrc_p0   <= 1'b0;
      regdst_p0   <= 1'b0;
      regwrite_p0 <= 1'b0;
      memtoreg_p0 <= 1'b0;
      memwrite_p0 <= 1'b0;
      vld_p0      <= 1'b0;
    end else if (!stall_e) begin
      rd1_p0      <= rd1_d;
      rd2_p0      <= rd2_d;
      imm_p0      <= signimm_d;
      rs_p0       <= rs_d;
      rt_p0       <= rt_d;
      rd_p0       <= rd_d;
      aluctl_p0   <= alucontrol_d;
      alusrc_p0   <= alusrc_d;
      regdst_p0   <= regdst_d;
      regwrite_p0 <= regwrite_d;
      memtoreg_p0 <= memtoreg_d;
      memwrite_p0 <= memwrite_d;
      vld_p0      <= valid_d;
    end
  end

  // ---- stage boundary: EX register -> combinational operand selection ----
  always_comb begin
    sel_a = fwd_select(rs_p0, regwrite_m, writereg_m, regwrite_w, writereg_w);
    sel_b = fwd_select(rt_p0, regwrite_m, writereg_m, regwrite_w, writereg_w);
    fwd_a = fwd_mux(sel_a, rd1_p0, aluout_m, result_w);
    fwd_b = fwd_mux(sel_b, rd2_p0, aluout_m, result_w);
  end

  assign srca_e      = fwd_a;
  assign writedata_e = fwd_b;
  assign srcb_e      = alusrc_p0 ? imm_p0 : fwd_b;
  assign aluf_e      = aluctl_p0;
  assign writereg_e  = regdst_p0 ? rd_p0 : rt_p0;
  assign regwrite_e  = regwrite_p0;
  assign memtoreg_e  = memtoreg_p0;
  assign memwrite_e  = memwrite_p0;
  assign valid_e     = vld_p0;
  assign fwda_e      = sel_a;
  assign fwdb_e      = sel_b;

  // A load in EX whose target is read by the instruction in decode cannot
  // be forwarded in time; ask the hazard unit to stall. The stage itself is
  // not cleared here, that is the hazard unit's decision.
  assign lwstall = memtoreg_p0 && vld_p0 && ((rt_p0 == rs_d) || (rt_p0 == rt_d));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the EX stage.
module tb_ex_operand_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] rd1_d, rd2_d, signimm_d;
  logic [4:0]   rs_d, rt_d, rd_d;
  logic [2:0]   alucontrol_d;
  logic         alusrc_d, regdst_d, regwrite_d, memtoreg_d, memwrite_d, valid_d;
  logic         stall_e, flush_e;
  logic [W-1:0] aluout_m, result_w;
  logic [4:0]   writereg_m, writereg_w;
  logic         regwrite_m, regwrite_w;

  logic [W-1:0] srca_e, srcb_e, writedata_e;
  logic [2:0]   aluf_e;
  logic [4:0]   writereg_e;
  logic         regwrite_e, memtoreg_e, memwrite_e, valid_e;
  logic [1:0]   fwda_e, fwdb_e;
  logic         lwstall;

  int checks = 0;
  int failures = 0;

  ex_operand_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d), .regdst_d(regdst_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
    .valid_d(valid_d), .stall_e(stall_e), .flush_e(flush_e),
    .aluout_m(aluout_m), .writereg_m(writereg_m), .regwrite_m(regwrite_m),
    .result_w(result_w), .writereg_w(writereg_w), .regwrite_w(regwrite_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .aluf_e(aluf_e),
    .writedata_e(writedata_e), .writereg_e(writereg_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
    .valid_e(valid_e), .fwda_e(fwda_e), .fwdb_e(fwdb_e), .lwstall(lwstall)
  );

  always #5 clk = ~clk;

  // Behavioural model: the instruction currently occupying EX
  typedef struct {
    logic [W-1:0] rd1, rd2, imm;
    logic [4:0]   rs, rt, rd;
    logic [2:0]   alu;
    logic         alusrc, regdst, regwrite, memtoreg, memwrite, valid;
  } inst_t;

  inst_t ex;

  function automatic inst_t bubble();
    inst_t b;
    b.rd1 = 0; b.rd2 = 0; b.imm = 0; b.rs = 0; b.rt = 0; b.rd = 0; b.alu = 0;
    b.alusrc = 0; b.regdst = 0; b.regwrite = 0; b.memtoreg = 0;
    b.memwrite = 0; b.valid = 0;
    return b;
  endfunction

  // Where a source register's value comes from right now: 2 = MEM, 1 = WB, 0 = regfile
  function automatic int source_of(input logic [4:0] r);
    if (r == 0) return 0;
    if (regwrite_m && writereg_m == r) return 2;
    if (regwrite_w && writereg_w == r) return 1;
    return 0;
  endfunction

  function automatic logic [W-1:0] value_of(input logic [4:0] r, input logic [W-1:0] rf);
    int s;
    s = source_of(r);
    if (s == 2) return aluout_m;
    if (s == 1) return result_w;
    return rf;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] b;
    b = value_of(ex.rt, ex.rd2);
    chk({tag, ".srca"},      srca_e, value_of(ex.rs, ex.rd1));
    chk({tag, ".srcb"},      srcb_e, ex.alusrc ? ex.imm : b);
    chk({tag, ".writedata"}, writedata_e, b);
    chk({tag, ".aluf"},      W'(aluf_e), W'(ex.alu));
    chk({tag, ".writereg"},  W'(writereg_e), W'(ex.regdst ? ex.rd : ex.rt));
    chk({tag, ".regwrite"},  W'(regwrite_e), W'(ex.regwrite));
    chk({tag, ".memtoreg"},  W'(memtoreg_e), W'(ex.memtoreg));
    chk({tag, ".memwrite"},  W'(memwrite_e), W'(ex.memwrite));
    chk({tag, ".valid"},     W'(valid_e), W'(ex.valid));
    chk({tag, ".fwda"},      W'(fwda_e), W'(source_of(ex.rs) == 2 ? 2'b10 : source_of(ex.rs) == 1 ? 2'b01 : 2'b00));
    chk({tag, ".fwdb"},      W'(fwdb_e), W'(source_of(ex.rt) == 2 ? 2'b10 : source_of(ex.rt) == 1 ? 2'b01 : 2'b00));
    chk({tag, ".lwstall"},   W'(lwstall),
        W'(ex.memtoreg && ex.valid && (ex.rt == rs_d || ex.rt == rt_d)));
  endtask

  // Advance one clock: update the model at the edge, return at the falling edge
  task automatic step();
    @(posedge clk);
    if (reset || flush_e) begin
      ex = bubble();
    end else if (!stall_e) begin
      ex.rd1 = rd1_d; ex.rd2 = rd2_d; ex.imm = signimm_d;
      ex.rs = rs_d; ex.rt = rt_d; ex.rd = rd_d; ex.alu = alucontrol_d;
      ex.alusrc = alusrc_d; ex.regdst = regdst_d; ex.regwrite = regwrite_d;
      ex.memtoreg = memtoreg_d; ex.memwrite = memwrite_d; ex.valid = valid_d;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; stall_e = 0; flush_e = 0;
    rd1_d = 0; rd2_d = 0; signimm_d = 0; rs_d = 0; rt_d = 0; rd_d = 0;
    alucontrol_d = 0; alusrc_d = 0; regdst_d = 0; regwrite_d = 0;
    memtoreg_d = 0; memwrite_d = 0; valid_d = 0;
    aluout_m = 0; writereg_m = 0; regwrite_m = 0;
    result_w = 0; writereg_w = 0; regwrite_w = 0;
  endtask

  task automatic random_decode();
    rd1_d = $urandom; rd2_d = $urandom; signimm_d = $urandom;
    rs_d = 5'($urandom_range(0, 7)); rt_d = 5'($urandom_range(0, 7));
    rd_d = 5'($urandom_range(0, 31));
    alucontrol_d = 3'($urandom); alusrc_d = 1'($urandom); regdst_d = 1'($urandom);
    regwrite_d = 1'($urandom); memtoreg_d = 1'($urandom);
    memwrite_d = 1'($urandom); valid_d = 1'($urandom);
  endtask

  task automatic random_forward();
    aluout_m = $urandom; result_w = $urandom;
    writereg_m = 5'($urandom_range(0, 7)); writereg_w = 5'($urandom_range(0, 7));
    regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
  endtask

  logic [W-1:0] held_srca, held_writedata;

  initial begin
    ex = bubble();
    idle_inputs();
    @(negedge clk);

    // Reset with garbage on the decode side
    reset = 1;
    random_decode();
    step();
    step();
    #1 check_all("reset");
    chk("reset.srca0", srca_e, 0);
    chk("reset.valid0", W'(valid_e), 0);
    idle_inputs();

    // Load and pass-through
    rd1_d = 5; rd2_d = 7; alusrc_d = 0; alucontrol_d = 3'b010; valid_d = 1;
    rs_d = 1; rt_d = 2;
    step();
    idle_inputs();
    #1 check_all("load");
    chk("load.srca", srca_e, 5);
    chk("load.srcb", srcb_e, 7);
    chk("load.aluf", W'(aluf_e), 2);
    chk("load.fwda", W'(fwda_e), 0);

    // Forward priority: MEM beats WB, then WB alone
    rs_d = 8; rd1_d = 32'h33; valid_d = 1;
    step();
    idle_inputs();
    regwrite_m = 1; writereg_m = 8; aluout_m = 32'h11;
    regwrite_w = 1; writereg_w = 8; result_w = 32'h22;
    #1 check_all("fwd_mem");
    chk("fwd_mem.srca", srca_e, 32'h11);
    chk("fwd_mem.fwda", W'(fwda_e), 2);
    regwrite_m = 0;
    #1 check_all("fwd_wb");
    chk("fwd_wb.srca", srca_e, 32'h22);
    chk("fwd_wb.fwda", W'(fwda_e), 1);

    // Register 0 never forwards
    idle_inputs();
    rt_d = 0; rd2_d = 0; valid_d = 1;
    step();
    regwrite_m = 1; writereg_m = 0; aluout_m = 32'hFF;
    regwrite_w = 1; writereg_w = 0; result_w = 32'hEE;
    #1 check_all("r0");
    chk("r0.writedata", writedata_e, 0);
    chk("r0.fwdb", W'(fwdb_e), 0);

    // Immediate select with rt forwarded from MEM
    idle_inputs();
    alusrc_d = 1; signimm_d = 32'hFFFF_FFFC; rt_d = 9; rd2_d = 32'h1234; valid_d = 1;
    step();
    idle_inputs();
    regwrite_m = 1; writereg_m = 9; aluout_m = 32'h9;
    #1 check_all("imm");
    chk("imm.srcb", srcb_e, 32'hFFFF_FFFC);
    chk("imm.writedata", writedata_e, 32'h9);

    // Stall for 3 cycles with changing inputs
    idle_inputs();
    random_decode();
    valid_d = 1; regwrite_d = 1; memwrite_d = 1; rs_d = 3; rt_d = 5;
    step();
    #1 held_srca = srca_e; held_writedata = writedata_e;
    for (int i = 0; i < 3; i++) begin
      random_decode();
      stall_e = 1;
      step();
      #1 check_all("stall");
      chk("stall.srca_held", srca_e, held_srca);
      chk("stall.writedata_held", writedata_e, held_writedata);
    end

    // Stall and flush together: flush wins
    flush_e = 1;
    step();
    flush_e = 0;
    #1 check_all("flush");
    chk("flush.regwrite", W'(regwrite_e), 0);
    chk("flush.memwrite", W'(memwrite_e), 0);
    chk("flush.valid", W'(valid_e), 0);

    // Reset in the middle of a stall discards the held instruction
    stall_e = 0;
    random_decode();
    valid_d = 1; regwrite_d = 1;
    step();
    stall_e = 1;
    random_decode();
    step();
    reset = 1;
    step();
    idle_inputs();
    #1 check_all("rst_stall");
    chk("rst_stall.valid", W'(valid_e), 0);
    chk("rst_stall.regwrite", W'(regwrite_e), 0);
    chk("rst_stall.writereg", W'(writereg_e), 0);

    // Load-use detection
    memtoreg_d = 1; valid_d = 1; rt_d = 4; rs_d = 6;
    step();
    idle_inputs();
    rs_d = 4; rt_d = 0;
    #1 check_all("lu_rs");
    chk("lu_rs.lwstall", W'(lwstall), 1);
    rs_d = 3; rt_d = 4;
    #1 check_all("lu_rt");
    chk("lu_rt.lwstall", W'(lwstall), 1);
    rs_d = 1; rt_d = 2;
    #1 check_all("lu_none");
    chk("lu_none.lwstall", W'(lwstall), 0);
    memtoreg_d = 1; valid_d = 0; rt_d = 4; rs_d = 4;
    step();
    #1 check_all("lu_invalid");
    chk("lu_invalid.lwstall", W'(lwstall), 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 99) < 3);
      flush_e = ($urandom_range(0, 99) < 10);
      stall_e = ($urandom_range(0, 99) < 20);
      random_decode();
      step();
      random_forward();
      #1 check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
